channel_scanner: RTL

CHANNEL_SCANNER -- requirements
Module: channel_scanner

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_dwell_counter.sv | 35 +++
 rtl/channel_scanner.sv | 133 +++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared constants and types for the channel scanner.
//   NCH    - number of channels behind the downstream mux
//   SEL_W  - width of the channel select
//   CNT_W  - width of the dwell counter (covers DWELL up to 255)
//   scan_state_e - scanner FSM states
package scan_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    Idle,
    Settle,
    Output
  } scan_state_e;

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell counter for the channel scanner.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   clear      - force the count back to zero (wins over enable)
//   enable     - advance the count by one
//   tc         - count has reached DWELL-1
module scan_dwell_counter
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TcVal = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tc = (count_q == TcVal);

endmodule

// File: rtl/channel_scanner.sv
// Sequences an external 8:1 mux through channels 0..7, waits DWELL cycles for
// each input to settle, captures the word and offers it on a valid/ready port.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start, continuous   - begin a scan (continuous = wrap 7->0), sampled in Idle
//   stop                - finish after the current channel's handshake
//   mux_data            - word returned by the mux for the current sel
//   sel                 - channel select to the mux
//   sample, sample_ch   - captured word and its channel
//   sample_valid        - sample is held until sample_ready
//   sample_ready        - consumer accept
//   busy, done          - not idle / one-cycle pulse on return to Idle
module channel_scanner
  import scan_pkg::*;
#(
  parameter int unsigned NBIT  = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  input  logic [NBIT-1:0]  mux_data,
  output logic [SEL_W-1:0] sel,
  output logic [NBIT-1:0]  sample,
  output logic [SEL_W-1:0] sample_ch,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LastCh = SEL_W'(NCH - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             cont_q, cont_d;
  logic             stop_pend_q, stop_pend_d;
  logic [NBIT-1:0]  sample_q, sample_d;
  logic [SEL_W-1:0] sample_ch_q, sample_ch_d;
  logic             done_q, done_d;
  logic             dwell_clear, dwell_en, dwell_tc;

  scan_dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (dwell_clear),
    .enable(dwell_en),
    .tc    (dwell_tc)
  );

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    done_d      = 1'b0;
    dwell_clear = 1'b1;
    dwell_en    = 1'b0;

    unique case (state_q)
      Idle: begin
        // stop alongside start vetoes the scan
        if (start && !stop) begin
          state_d     = Settle;
          chan_d      = '0;
          cont_d      = continuous;
          stop_pend_d = 1'b0;
        end
      end
      Settle: begin
        dwell_clear = 1'b0;
        dwell_en    = 1'b1;
        if (stop) stop_pend_d = 1'b1;
        if (dwell_tc) begin
          sample_d    = mux_data;
          sample_ch_d = chan_q;
          state_d     = Output;
        end
      end
      Output: begin
        if (stop) stop_pend_d = 1'b1;
        if (sample_ready) begin
          if (!(stop_pend_q || stop) && (chan_q != LastCh || cont_q)) begin
            // channel 7 wraps to 0 naturally in continuous mode
            chan_d  = chan_q + SEL_W'(1);
            state_d = Settle;
          end else begin
            state_d     = Idle;
            chan_d      = '0;
            cont_d      = 1'b0;
            stop_pend_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= Idle;
      chan_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      done_q      <= done_d;
    end
  end

  assign sel          = chan_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = (state_q == Output);
  assign busy         = (state_q != Idle);
  assign done         = done_q;

endmodule
